// File: rtl/if_bht_fetch.sv
// Instruction fetch stage: direct-mapped I-cache (one word per line), table of 2-bit
// branch predictors indexed by PC, static JAL redirection, and ROB-driven redirect.
module if_bht_fetch #(
  parameter int unsigned PC_BITS         = 18,
  parameter int unsigned ICACHE_IDX_BITS = 8,
  parameter int unsigned BHT_IDX_BITS    = 6,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_rst,
  input  logic [31:0] jump_pc,
  input  logic        RS_full,
  input  logic        SLB_full,
  input  logic        ROB_full,
  output logic        ID_send,
  output logic [31:0] instruction,
  output logic        pred_result,
  output logic [31:0] inst_pc,
  input  logic        mem_valid,
  input  logic [31:0] mem_val,
  output logic        mem_send,
  output logic [31:0] mem_addr,
  input  logic        pred,
  input  logic [31:0] pred_pc,
  input  logic        pred_val
);

  localparam int unsigned LINES       = 1 << ICACHE_IDX_BITS;
  localparam int unsigned BHT_ENTRIES = 1 << BHT_IDX_BITS;
  localparam int unsigned TAG_BITS    = PC_BITS - ICACHE_IDX_BITS - 2;
  localparam int unsigned HI_BITS     = 32 - PC_BITS;
  localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
  localparam logic [6:0]  OP_JAL      = 7'b1101111;

  typedef enum logic {IDLE, MISS} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_send_q, id_send_d;
  logic [31:0] instruction_q, instruction_d;
  logic        pred_result_q, pred_result_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        mem_send_q, mem_send_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];
  logic [1:0]          cnt_q  [BHT_ENTRIES];

  logic [ICACHE_IDX_BITS-1:0] look_idx, fill_idx;
  logic [TAG_BITS-1:0]        look_tag, fill_tag;
  logic [BHT_IDX_BITS-1:0]    bht_idx, upd_idx;
  logic                       hit, stall, fill_we, bht_taken;
  logic [31:0]                word, imm_b, imm_j;
  logic [1:0]                 upd_cnt;
  logic                       unused_pred_pc;

  assign unused_pred_pc = ^{pred_pc[31:BHT_IDX_BITS+2], pred_pc[1:0]};

  // Cache/predictor lookup on the current pc and decode of the cached word
  always_comb begin : lookup
    look_idx  = pc_q[ICACHE_IDX_BITS+1:2];
    look_tag  = pc_q[PC_BITS-1:ICACHE_IDX_BITS+2];
    hit       = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    word      = data_q[look_idx];
    bht_idx   = pc_q[BHT_IDX_BITS+1:2];
    bht_taken = cnt_q[bht_idx][1];
    imm_b     = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
    imm_j     = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
    stall     = RS_full || SLB_full || ROB_full;
    fill_idx  = mem_addr_q[ICACHE_IDX_BITS+1:2];
    fill_tag  = mem_addr_q[PC_BITS-1:ICACHE_IDX_BITS+2];
    fill_we   = (state_q == MISS) && mem_valid && !jump_rst;
  end

  // Saturating counter step for the resolved branch
  always_comb begin : bht_update
    upd_idx = pred_pc[BHT_IDX_BITS+1:2];
    upd_cnt = cnt_q[upd_idx];
    if (pred_val && (cnt_q[upd_idx] != 2'b11)) begin
      upd_cnt = cnt_q[upd_idx] + 2'b01;
    end else if (!pred_val && (cnt_q[upd_idx] != 2'b00)) begin
      upd_cnt = cnt_q[upd_idx] - 2'b01;
    end
  end

  always_comb begin : fetch_fsm
    state_d       = state_q;
    pc_d          = pc_q;
    id_send_d     = 1'b0;
    instruction_d = instruction_q;
    pred_result_d = pred_result_q;
    inst_pc_d     = inst_pc_q;
    mem_send_d    = mem_send_q;
    mem_addr_d    = mem_addr_q;
    if (jump_rst) begin
      // Redirect wins: aborts an outstanding refill and suppresses issue
      pc_d       = jump_pc;
      state_d    = IDLE;
      mem_send_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            state_d    = MISS;
            mem_send_d = 1'b1;
            mem_addr_d = {{HI_BITS{1'b0}}, pc_q[PC_BITS-1:2], 2'b00};
          end else if (!stall) begin
            id_send_d     = 1'b1;
            instruction_d = word;
            inst_pc_d     = pc_q;
            if (word[6:0] == OP_JAL) begin
              pc_d          = pc_q + imm_j;
              pred_result_d = 1'b1;
            end else if ((word[6:0] == OP_BRANCH) && bht_taken) begin
              pc_d          = pc_q + imm_b;
              pred_result_d = 1'b1;
            end else begin
              pc_d          = pc_q + 32'd4;
              pred_result_d = 1'b0;
            end
          end
        end
        MISS: begin
          if (mem_valid) begin
            state_d    = IDLE;
            mem_send_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin : fetch_regs
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      id_send_q     <= 1'b0;
      instruction_q <= 32'h0;
      pred_result_q <= 1'b0;
      inst_pc_q     <= 32'h0;
      mem_send_q    <= 1'b0;
      mem_addr_q    <= 32'h0;
    end else if (rdy) begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_send_q     <= id_send_d;
      instruction_q <= instruction_d;
      pred_result_q <= pred_result_d;
      inst_pc_q     <= inst_pc_d;
      mem_send_q    <= mem_send_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  // Valid bits and predictor counters need reset; tag/data do not
  always_ff @(posedge clk or posedge rst) begin : valid_bht_regs
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        cnt_q[BHT_IDX_BITS'(i)] <= 2'b01;
      end
    end else if (rdy) begin
      if (fill_we) valid_q[fill_idx] <= 1'b1;
      if (pred) cnt_q[upd_idx] <= upd_cnt;
    end
  end

  always_ff @(posedge clk) begin : line_regs
    if (rdy && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_val;
    end
  end

  assign ID_send     = id_send_q;
  assign instruction = instruction_q;
  assign pred_result = pred_result_q;
  assign inst_pc     = inst_pc_q;
  assign mem_send    = mem_send_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_if_bht_fetch.sv
// Bench for if_bht_fetch: directed scenarios, then randomized traffic checked against a
// program-order model of the fetch stream and predictor table.
module tb_if_bht_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_rst, RS_full, SLB_full, ROB_full;
  logic [31:0] jump_pc;
  logic        ID_send, pred_result, mem_send, mem_valid;
  logic [31:0] instruction, inst_pc, mem_addr, mem_val;
  logic        pred, pred_val;
  logic [31:0] pred_pc;

  logic        mem_en = 1'b0;
  logic        man_valid, rsp_valid;
  logic [31:0] man_val, rsp_val;
  int          lat = 0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] p_word [int unsigned];
  int          p_kind [int unsigned];
  int          p_off  [int unsigned];

  assign mem_valid = mem_en ? rsp_valid : man_valid;
  assign mem_val   = mem_en ? rsp_val   : man_val;

  always #5 clk = ~clk;

  if_bht_fetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_rst(jump_rst), .jump_pc(jump_pc),
    .RS_full(RS_full), .SLB_full(SLB_full), .ROB_full(ROB_full),
    .ID_send(ID_send), .instruction(instruction), .pred_result(pred_result), .inst_pc(inst_pc),
    .mem_valid(mem_valid), .mem_val(mem_val), .mem_send(mem_send), .mem_addr(mem_addr),
    .pred(pred), .pred_pc(pred_pc), .pred_val(pred_val)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_b(input int off);
    logic [12:0] b;
    b = 13'(off);
    return {b[12], b[10:5], 5'd2, 5'd1, 3'b001, b[4:1], b[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int off);
    logic [20:0] j;
    j = 21'(off);
    return {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111};
  endfunction

  // kind 0 = addi (off = immediate), 1 = conditional branch, 2 = jal
  function automatic void place(input int unsigned a, input int kind, input int off);
    p_kind[a] = kind;
    p_off[a]  = off;
    case (kind)
      1:       p_word[a] = enc_b(off);
      2:       p_word[a] = enc_j(off);
      default: p_word[a] = {12'(off), 5'd0, 3'b000, 5'd1, 7'b0010011};
    endcase
  endfunction

  function automatic logic [31:0] word_at(input int unsigned a);
    int r;
    if (!p_word.exists(a)) begin
      r = int'($urandom_range(0, 3));
      if (r < 2) place(a, 0, int'($urandom_range(0, 2047)));
      else place(a, r - 1, (int'($urandom_range(0, 32)) - 16) * 4);
    end
    return p_word[a];
  endfunction

  // Memory model: answers an open request after a random 0-2 cycle delay
  always @(negedge clk) begin
    if (mem_en) begin
      rsp_valid = 1'b0;
      if (mem_send && !rst) begin
        if (lat == 0) begin
          rsp_valid = 1'b1;
          rsp_val   = word_at(mem_addr);
          lat       = int'($urandom_range(0, 2));
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic jump(input logic [31:0] a);
    jump_rst = 1'b1;
    jump_pc  = a;
    tick();
    jump_rst = 1'b0;
  endtask

  task automatic wait_send(input string tag);
    int n = 0;
    tick();
    while (!ID_send && n < 60) begin
      tick();
      n++;
    end
    if (!ID_send) check({tag, "_timeout"}, 32'(ID_send), 32'd1);
  endtask

  task automatic upd(input logic [31:0] a, input logic v, input int n);
    pred     = 1'b1;
    pred_pc  = a;
    pred_val = v;
    repeat (n) tick();
    pred = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_id_send"}, 32'(ID_send), 32'd0);
    check({tag, "_mem_send"}, 32'(mem_send), 32'd0);
    check({tag, "_pred_result"}, 32'(pred_result), 32'd0);
    check({tag, "_instruction"}, instruction, 32'd0);
    check({tag, "_inst_pc"}, inst_pc, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
  endtask

  int          cnt [64];
  logic [31:0] exp_pc;
  logic        cur_rdy, cur_jump, cur_stall, cur_pred, cur_pval, prev_id, prev_ms, exp_taken;
  logic [31:0] cur_jpc, cur_ppc;
  int          issues;

  initial begin
    rst = 1'b1; rdy = 1'b1; jump_rst = 1'b0; jump_pc = 32'h0;
    RS_full = 1'b0; SLB_full = 1'b0; ROB_full = 1'b0;
    pred = 1'b0; pred_pc = 32'h0; pred_val = 1'b0;
    man_valid = 1'b0; man_val = 32'h0; rsp_valid = 1'b0; rsp_val = 32'h0;

    place(32'h0, 0, 1);
    for (int a = 32'h40; a <= 32'h5C; a += 4) place(a, 0, a);
    place(32'h100, 1, -8);
    place(32'h104, 0, 7);
    place(32'hF8, 0, 9);
    place(32'h200, 2, 32'h800);
    place(32'hA00, 0, 3);
    place(32'h5000, 0, 5);

    // Reset and first refill
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("first_req_send", 32'(mem_send), 32'd1);
    check("first_req_addr", mem_addr, 32'h0);
    man_valid = 1'b1;
    man_val   = word_at(32'h0);
    tick();
    man_valid = 1'b0;
    check("refill_send_drop", 32'(mem_send), 32'd0);
    check("refill_no_early_id", 32'(ID_send), 32'd0);
    tick();
    check("first_id_send", 32'(ID_send), 32'd1);
    check("first_instruction", instruction, 32'h00100093);
    check("first_inst_pc", inst_pc, 32'h0);
    check("first_pred", 32'(pred_result), 32'd0);
    tick();
    check("second_id_low", 32'(ID_send), 32'd0);
    check("second_req_send", 32'(mem_send), 32'd1);
    check("second_req_addr", mem_addr, 32'h4);

    // Cached line re-executes immediately after redirect
    mem_en = 1'b1;
    jump(32'h40);
    wait_send("fill40");
    check("fill40_pc", inst_pc, 32'h40);
    wait_send("fill44");
    check("fill44_pc", inst_pc, 32'h44);
    jump(32'h40);
    tick();
    check("rehit_id", 32'(ID_send), 32'd1);
    check("rehit_pc", inst_pc, 32'h40);
    check("rehit_no_req", 32'(mem_send), 32'd0);

    // Stall: ROB_full held five cycles on a hitting pc
    ROB_full = 1'b1;
    jump(32'h40);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_id", 32'(ID_send), 32'd0);
    end
    ROB_full = 1'b0;
    tick();
    check("resume1_id", 32'(ID_send), 32'd1);
    check("resume1_pc", inst_pc, 32'h40);
    tick();
    check("resume2_id", 32'(ID_send), 32'd1);
    check("resume2_pc", inst_pc, 32'h44);

    // Branch at 0x100 with offset -8 under changing counter state
    jump(32'h100);
    wait_send("br_a");
    check("br_a_pc", inst_pc, 32'h100);
    check("br_a_pred", 32'(pred_result), 32'd0);
    wait_send("br_a_next");
    check("br_a_next_pc", inst_pc, 32'h104);
    ROB_full = 1'b1;
    upd(32'h100, 1'b1, 2);
    jump(32'h100);
    ROB_full = 1'b0;
    wait_send("br_b");
    check("br_b_pred", 32'(pred_result), 32'd1);
    check("br_b_pc", inst_pc, 32'h100);
    wait_send("br_b_next");
    check("br_b_next_pc", inst_pc, 32'hF8);
    ROB_full = 1'b1;
    upd(32'h100, 1'b1, 1);
    upd(32'h100, 1'b0, 2);
    jump(32'h100);
    ROB_full = 1'b0;
    wait_send("br_sat_hi");
    check("br_sat_hi_pred", 32'(pred_result), 32'd0);
    ROB_full = 1'b1;
    upd(32'h100, 1'b0, 4);
    jump(32'h100);
    ROB_full = 1'b0;
    wait_send("br_sat_lo");
    check("br_sat_lo_pred", 32'(pred_result), 32'd0);
    wait_send("br_sat_lo_next");
    check("br_sat_lo_next_pc", inst_pc, 32'h104);
    ROB_full = 1'b1;
    upd(32'h100, 1'b1, 1);
    jump(32'h100);
    ROB_full = 1'b0;
    wait_send("br_sat_lo_inc");
    check("br_sat_lo_inc_pred", 32'(pred_result), 32'd0);

    // JAL at 0x200, offset +0x800
    jump(32'h200);
    wait_send("jal");
    check("jal_pc", inst_pc, 32'h200);
    check("jal_pred", 32'(pred_result), 32'd1);
    check("jal_word", instruction, p_word[32'h200]);
    wait_send("jal_next");
    check("jal_next_pc", inst_pc, 32'hA00);

    // Refill aborted by a redirect in the same cycle as mem_valid
    mem_en = 1'b0;
    man_valid = 1'b0;
    jump(32'h5000);
    tick();
    check("abort_req_send", 32'(mem_send), 32'd1);
    check("abort_req_addr", mem_addr, 32'h5000);
    man_valid = 1'b1;
    man_val   = word_at(32'h5000);
    jump_rst  = 1'b1;
    jump_pc   = 32'h300;
    tick();
    jump_rst  = 1'b0;
    man_valid = 1'b0;
    check("abort_send_drop", 32'(mem_send), 32'd0);
    check("abort_no_id", 32'(ID_send), 32'd0);
    tick();
    check("abort_next_send", 32'(mem_send), 32'd1);
    check("abort_next_addr", mem_addr, 32'h300);
    jump(32'h5000);
    tick();
    check("abort_line_empty_send", 32'(mem_send), 32'd1);
    check("abort_line_empty_addr", mem_addr, 32'h5000);
    check("abort_line_empty_id", 32'(ID_send), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");

    // Randomized traffic against the program-order model
    repeat (2) tick();
    for (int i = 0; i < 64; i++) cnt[i] = 1;
    exp_pc  = 32'h0;
    prev_id = 1'b0;
    prev_ms = 1'b0;
    issues  = 0;
    mem_en  = 1'b1;
    rst     = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      cur_rdy   = (cyc == 0) || ($urandom_range(0, 9) != 0);
      cur_jump  = (cyc == 0) || ($urandom_range(0, 29) == 0);
      cur_jpc   = 32'h8000 + 32'($urandom_range(0, 255)) * 4;
      RS_full   = ($urandom_range(0, 11) == 0);
      SLB_full  = ($urandom_range(0, 11) == 0);
      ROB_full  = ($urandom_range(0, 11) == 0);
      cur_stall = RS_full || SLB_full || ROB_full;
      cur_pred  = ($urandom_range(0, 4) == 0);
      cur_ppc   = 32'h8000 + 32'($urandom_range(0, 511)) * 4;
      cur_pval  = 1'($urandom_range(0, 1));
      rdy = cur_rdy; jump_rst = cur_jump; jump_pc = cur_jpc;
      pred = cur_pred; pred_pc = cur_ppc; pred_val = cur_pval;
      tick();
      if (!cur_rdy) begin
        check("hold_id_send", 32'(ID_send), 32'(prev_id));
        check("hold_mem_send", 32'(mem_send), 32'(prev_ms));
      end else begin
        if (mem_send && !prev_ms) check("req_addr", mem_addr, exp_pc);
        if (cur_jump || cur_stall) begin
          check("no_issue", 32'(ID_send), 32'd0);
        end else if (ID_send) begin
          issues++;
          check("stream_pc", inst_pc, exp_pc);
          check("stream_word", instruction, word_at(exp_pc));
          exp_taken = (p_kind[exp_pc] == 2) ||
                      (p_kind[exp_pc] == 1 && cnt[(exp_pc >> 2) % 64] >= 2);
          check("stream_pred", 32'(pred_result), 32'(exp_taken));
          exp_pc = exp_taken ? exp_pc + 32'(p_off[exp_pc]) : exp_pc + 32'd4;
        end
        if (cur_jump) exp_pc = cur_jpc;
        if (cur_pred) begin
          if (cur_pval && cnt[(cur_ppc >> 2) % 64] < 3) cnt[(cur_ppc >> 2) % 64]++;
          else if (!cur_pval && cnt[(cur_ppc >> 2) % 64] > 0) cnt[(cur_ppc >> 2) % 64]--;
        end
      end
      prev_id = ID_send;
      prev_ms = mem_send;
    end
    check("min_issues", 32'(issues >= 50), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
